// File: rtl/lga_pkg.sv
// Shared types for the FHP-II lattice-gas sweep sequencer.
// Holds the sweep state encoding, the coordinate width and the row-phase type.
package lga_pkg;

    localparam int unsigned COORD_W = 9;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StSwap,
        StDone
    } sweep_state_e;

    typedef logic [1:0] phase3_t;

    function automatic phase3_t phase3_next(input phase3_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/lga_coord_counter.sv
// Raster x/y counters with an incremental y mod 3 phase.
// The phase wraps with y, so no divider is needed.
module lga_coord_counter
    import lga_pkg::*;
#(
    parameter int unsigned LAT_W = 64,
    parameter int unsigned LAT_H = 63
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               advance_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output phase3_t            ymod3_o,
    output logic               eol_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] XMax = COORD_W'(LAT_W - 1);
    localparam logic [COORD_W-1:0] YMax = COORD_W'(LAT_H - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    phase3_t            ymod3_q, ymod3_d;

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign ymod3_o = ymod3_q;
    assign eol_o   = (x_q == XMax);
    assign last_o  = eol_o && (y_q == YMax);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        ymod3_d = ymod3_q;
        if (clear_i) begin
            x_d     = '0;
            y_d     = '0;
            ymod3_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                x_d = '0;
                // Last cell of the frame wraps the whole coordinate back to the origin.
                if (last_o) begin
                    y_d     = '0;
                    ymod3_d = '0;
                end else begin
                    y_d     = y_q + COORD_W'(1);
                    ymod3_d = phase3_next(ymod3_q);
                end
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q     <= '0;
            y_q     <= '0;
            ymod3_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            ymod3_q <= ymod3_d;
        end
    end

endmodule

// File: rtl/lga_sweep_ctrl.sv
// Sweep sequencer: raster-scans the lattice for n_steps time steps, one cell per handshake,
// with a one-cycle buffer-swap gap between steps and a done pulse at the end.
module lga_sweep_ctrl
    import lga_pkg::*;
#(
    parameter int unsigned LAT_W  = 64,
    parameter int unsigned LAT_H  = 63,
    parameter int unsigned STEP_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [STEP_W-1:0]  n_steps,
    output logic               cell_valid,
    input  logic               cell_ready,
    output logic [COORD_W-1:0] cell_x,
    output logic [COORD_W-1:0] cell_y,
    output logic [1:0]         cell_ymod3,
    output logic               cell_eol,
    output logic               cell_last,
    output logic [STEP_W-1:0]  step_count,
    output logic               swap_buf,
    output logic               busy,
    output logic               done
);

    sweep_state_e      state_q;
    logic [STEP_W-1:0] n_lat_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_inc;
    logic              valid_q, swap_q, done_q, busy_q;
    logic              cnt_clear, cnt_advance, cnt_eol, cnt_last;
    phase3_t           cnt_ymod3;

    assign step_inc    = step_q + STEP_W'(1);
    assign cnt_advance = valid_q && cell_ready;
    assign cnt_clear   = abort || ((state_q == StIdle) && start);

    lga_coord_counter #(
        .LAT_W (LAT_W),
        .LAT_H (LAT_H)
    ) u_coord (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (cnt_clear),
        .advance_i (cnt_advance),
        .x_o       (cell_x),
        .y_o       (cell_y),
        .ymod3_o   (cnt_ymod3),
        .eol_o     (cnt_eol),
        .last_o    (cnt_last)
    );

    assign cell_ymod3 = cnt_ymod3;
    assign cell_valid = valid_q;
    assign cell_eol   = valid_q && cnt_eol;
    assign cell_last  = valid_q && cnt_last;
    assign step_count = step_q;
    assign swap_buf   = swap_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            n_lat_q <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
            swap_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            swap_q <= 1'b0;
            done_q <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            n_lat_q <= n_steps;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                            if (n_steps == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StScan;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    StScan: begin
                        if (cell_ready && cnt_last) begin
                            step_q  <= step_inc;
                            valid_q <= 1'b0;
                            if (step_inc == n_lat_q) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StSwap;
                                swap_q  <= 1'b1;
                            end
                        end
                    end
                    StSwap: begin
                        state_q <= StScan;
                        valid_q <= 1'b1;
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lga_sweep_ctrl.sv
// Bench for lga_sweep_ctrl: a 4x3 instance and a default 64x63 instance, each tracked by a
// cell-index model and compared every cycle, plus directed scenarios with literal expectations.
module tb_lga_sweep_ctrl;

    localparam int unsigned STEP_W = 16;
    localparam int NI = 2;

    localparam int MIdle = 0;
    localparam int MScan = 1;
    localparam int MGap  = 2;
    localparam int MFin  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_s   [NI];
    logic              start_s [NI];
    logic              abort_s [NI];
    logic              ready_s [NI];
    logic [STEP_W-1:0] nst_s   [NI];

    logic              valid_o [NI];
    logic [8:0]        x_o     [NI];
    logic [8:0]        y_o     [NI];
    logic [1:0]        ym_o    [NI];
    logic              eol_o   [NI];
    logic              last_o  [NI];
    logic [STEP_W-1:0] sc_o    [NI];
    logic              swap_o  [NI];
    logic              busy_o  [NI];
    logic              done_o  [NI];

    lga_sweep_ctrl #(
        .LAT_W  (4),
        .LAT_H  (3),
        .STEP_W (STEP_W)
    ) u_small (
        .clk        (clk),
        .rst        (rst_s[0]),
        .start      (start_s[0]),
        .abort      (abort_s[0]),
        .n_steps    (nst_s[0]),
        .cell_valid (valid_o[0]),
        .cell_ready (ready_s[0]),
        .cell_x     (x_o[0]),
        .cell_y     (y_o[0]),
        .cell_ymod3 (ym_o[0]),
        .cell_eol   (eol_o[0]),
        .cell_last  (last_o[0]),
        .step_count (sc_o[0]),
        .swap_buf   (swap_o[0]),
        .busy       (busy_o[0]),
        .done       (done_o[0])
    );

    lga_sweep_ctrl u_dflt (
        .clk        (clk),
        .rst        (rst_s[1]),
        .start      (start_s[1]),
        .abort      (abort_s[1]),
        .n_steps    (nst_s[1]),
        .cell_valid (valid_o[1]),
        .cell_ready (ready_s[1]),
        .cell_x     (x_o[1]),
        .cell_y     (y_o[1]),
        .cell_ymod3 (ym_o[1]),
        .cell_eol   (eol_o[1]),
        .cell_last  (last_o[1]),
        .step_count (sc_o[1]),
        .swap_buf   (swap_o[1]),
        .busy       (busy_o[1]),
        .done       (done_o[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    function automatic int wd(input int i);
        return (i == 0) ? 4 : 64;
    endfunction

    function automatic int ht(input int i);
        return (i == 0) ? 3 : 63;
    endfunction

    function automatic int mod3_lut(input logic [8:0] y);
        return int'(y) % 3;
    endfunction

    task automatic chk(input int inst, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL u%0d %s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
        end
    endtask

    // Model: a run is a sequence of linear cell indices per step; coordinates follow by div/mod.
    int m_mode [NI];
    int m_idx  [NI];
    int m_stp  [NI];
    int m_nlat [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_s[i]) begin
                m_mode[i] = MIdle;
                m_idx[i]  = 0;
                m_stp[i]  = 0;
                m_nlat[i] = 0;
            end else if (abort_s[i]) begin
                m_mode[i] = MIdle;
            end else begin
                case (m_mode[i])
                    MIdle: if (start_s[i]) begin
                        m_nlat[i] = int'(nst_s[i]);
                        m_stp[i]  = 0;
                        m_idx[i]  = 0;
                        m_mode[i] = (nst_s[i] == 0) ? MFin : MScan;
                    end
                    MScan: if (ready_s[i]) begin
                        if (m_idx[i] == wd(i) * ht(i) - 1) begin
                            m_idx[i]  = 0;
                            m_stp[i]  = m_stp[i] + 1;
                            m_mode[i] = (m_stp[i] == m_nlat[i]) ? MFin : MGap;
                        end else begin
                            m_idx[i] = m_idx[i] + 1;
                        end
                    end
                    MGap:    m_mode[i] = MScan;
                    default: m_mode[i] = MIdle;
                endcase
            end
        end
    end

    logic       p_hold [NI];
    logic [8:0] p_x    [NI];
    logic [8:0] p_y    [NI];
    logic [1:0] p_ym   [NI];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                bit ev;
                int ex, ey;
                ev = (m_mode[i] == MScan);
                ex = m_idx[i] % wd(i);
                ey = m_idx[i] / wd(i);
                chk(i, "valid", 32'(valid_o[i]), 32'(ev));
                chk(i, "busy", 32'(busy_o[i]), 32'(m_mode[i] != MIdle));
                chk(i, "swap_buf", 32'(swap_o[i]), 32'(m_mode[i] == MGap));
                chk(i, "done", 32'(done_o[i]), 32'(m_mode[i] == MFin));
                chk(i, "step_count", 32'(sc_o[i]), m_stp[i]);
                chk(i, "eol", 32'(eol_o[i]), 32'(ev && ex == wd(i) - 1));
                chk(i, "last", 32'(last_o[i]), 32'(ev && m_idx[i] == wd(i) * ht(i) - 1));
                if (ev) begin
                    chk(i, "x", 32'(x_o[i]), ex);
                    chk(i, "y", 32'(y_o[i]), ey);
                    chk(i, "ymod3", 32'(ym_o[i]), ey % 3);
                    chk(i, "ymod3_lut", 32'(ym_o[i]), mod3_lut(y_o[i]));
                    if (p_hold[i]) begin
                        chk(i, "hold_xy", {14'b0, x_o[i], y_o[i]}, {14'b0, p_x[i], p_y[i]});
                        chk(i, "hold_ym", 32'(ym_o[i]), 32'(p_ym[i]));
                    end
                end
                p_hold[i] = valid_o[i] && !ready_s[i];
                p_x[i]    = x_o[i];
                p_y[i]    = y_o[i];
                p_ym[i]   = ym_o[i];
            end
        end
    end

    int ob_x[$], ob_y[$], ob_ym[$], ob_cyc[$];
    int ob_done_cyc, ob_swaps, ob_swap_cyc, ob_vseen;
    logic [STEP_W-1:0] ob_sc;

    task automatic observe(input int i, input int budget, input bit rnd);
        ob_x.delete(); ob_y.delete(); ob_ym.delete(); ob_cyc.delete();
        ob_done_cyc = -1;
        ob_swaps    = 0;
        ob_swap_cyc = -1;
        ob_vseen    = 0;
        ob_sc       = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (valid_o[i]) ob_vseen++;
            if (valid_o[i] && ready_s[i]) begin
                ob_x.push_back(int'(x_o[i]));
                ob_y.push_back(int'(y_o[i]));
                ob_ym.push_back(int'(ym_o[i]));
                ob_cyc.push_back(c);
            end
            if (swap_o[i]) begin
                ob_swaps++;
                ob_swap_cyc = c;
            end
            if (done_o[i]) begin
                ob_done_cyc = c;
                ob_sc       = sc_o[i];
                break;
            end
            if (rnd) begin
                @(posedge clk);
                #1;
                ready_s[i] = 1'($urandom_range(0, 1));
            end
        end
        chk(i, "done_within_budget", 32'(ob_done_cyc >= 0), 1);
        ready_s[i] = 1'b1;
    endtask

    task automatic launch(input int i, input logic [STEP_W-1:0] n);
        @(posedge clk);
        #1;
        nst_s[i]   = n;
        start_s[i] = 1'b1;
        @(posedge clk);
        #1;
        start_s[i] = 1'b0;
    endtask

    int exp_x[12]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int exp_y[12]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    initial begin
        bit found;
        int dn;
        for (int i = 0; i < NI; i++) begin
            rst_s[i]   = 1'b1;
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
            ready_s[i] = 1'b1;
            nst_s[i]   = '0;
            p_hold[i]  = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk(i, "rst_valid", 32'(valid_o[i]), 0);
            chk(i, "rst_busy", 32'(busy_o[i]), 0);
            chk(i, "rst_step_count", 32'(sc_o[i]), 0);
            chk(i, "rst_xy", {14'b0, x_o[i], y_o[i]}, 0);
        end
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        // Two full steps at 4x3 with ready held high.
        launch(0, 16'd2);
        observe(0, 100, 1'b0);
        chk(0, "t1_cells", ob_x.size(), 24);
        if (ob_x.size() >= 24) begin
            for (int k = 0; k < 24; k++) begin
                chk(0, $sformatf("t1_x%0d", k), ob_x[k], exp_x[k % 12]);
                chk(0, $sformatf("t1_y%0d", k), ob_y[k], exp_y[k % 12]);
                chk(0, $sformatf("t1_ym%0d", k), ob_ym[k], exp_y[k % 12]);
            end
            chk(0, "t1_swap_after_12th", ob_swap_cyc, ob_cyc[11] + 1);
            chk(0, "t1_done_after_24th", ob_done_cyc, ob_cyc[23] + 1);
        end
        chk(0, "t1_swaps", ob_swaps, 1);
        chk(0, "t1_done_cycle", ob_done_cyc, 25);
        chk(0, "t1_step_count", 32'(ob_sc), 2);

        // Random backpressure.
        launch(0, 16'd2);
        observe(0, 600, 1'b1);
        chk(0, "t2_cells", ob_x.size(), 24);
        chk(0, "t2_swaps", ob_swaps, 1);
        chk(0, "t2_step_count", 32'(ob_sc), 2);

        // Zero-step run.
        launch(0, 16'd0);
        observe(0, 10, 1'b0);
        chk(0, "t3_done_cycle", ob_done_cyc, 0);
        chk(0, "t3_no_valid", ob_vseen, 0);
        chk(0, "t3_step_count", 32'(ob_sc), 0);

        // Abort at (2,1) of the second step, then restart.
        launch(0, 16'd3);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (valid_o[0] && x_o[0] == 9'd2 && y_o[0] == 9'd1 && sc_o[0] == 16'd1) found = 1'b1;
        end
        chk(0, "t4_reach_abort_point", 32'(found), 1);
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[0] = 1'b0;
        @(negedge clk);
        chk(0, "t4_busy", 32'(busy_o[0]), 0);
        chk(0, "t4_valid", 32'(valid_o[0]), 0);
        chk(0, "t4_step_count", 32'(sc_o[0]), 1);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_o[0] || swap_o[0]) dn++;
        end
        chk(0, "t4_no_done_swap", dn, 0);
        launch(0, 16'd1);
        observe(0, 50, 1'b0);
        chk(0, "t4_restart_cells", ob_x.size(), 12);
        if (ob_x.size() > 0) begin
            chk(0, "t4_restart_x", ob_x[0], 0);
            chk(0, "t4_restart_y", ob_y[0], 0);
        end
        chk(0, "t4_restart_sc", 32'(ob_sc), 1);

        // start re-pulsed and n_steps changed mid-run.
        launch(0, 16'd2);
        fork
            observe(0, 100, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                start_s[0] = 1'b1;
                nst_s[0]   = 16'd7;
                @(posedge clk);
                #1;
                start_s[0] = 1'b0;
                nst_s[0]   = 16'd1;
            end
        join
        chk(0, "t5_cells", ob_x.size(), 24);
        chk(0, "t5_step_count", 32'(ob_sc), 2);

        // Default 64x63: reset during SWAP, then a full single-step sweep.
        launch(1, 16'd2);
        found = 1'b0;
        for (int c = 0; c < 5000 && !found; c++) begin
            @(negedge clk);
            if (swap_o[1]) found = 1'b1;
        end
        chk(1, "t6_reach_swap", 32'(found), 1);
        rst_s[1] = 1'b1;
        @(negedge clk);
        chk(1, "t6_rst_valid", 32'(valid_o[1]), 0);
        chk(1, "t6_rst_busy", 32'(busy_o[1]), 0);
        chk(1, "t6_rst_swap_done", {30'b0, swap_o[1], done_o[1]}, 0);
        chk(1, "t6_rst_sc", 32'(sc_o[1]), 0);
        chk(1, "t6_rst_xy", {14'b0, x_o[1], y_o[1]}, 0);
        chk(1, "t6_rst_ym_eol_last", {28'b0, ym_o[1], eol_o[1], last_o[1]}, 0);
        @(posedge clk);
        #1;
        rst_s[1] = 1'b0;
        launch(1, 16'd1);
        observe(1, 5000, 1'b0);
        chk(1, "t6_cells", ob_x.size(), 4032);
        if (ob_x.size() > 0) begin
            chk(1, "t6_last_x", ob_x[ob_x.size() - 1], 63);
            chk(1, "t6_last_y", ob_y[ob_y.size() - 1], 62);
            chk(1, "t6_last_ym", ob_ym[ob_ym.size() - 1], 2);
        end
        chk(1, "t6_done_cycle", ob_done_cyc, 4032);
        chk(1, "t6_swaps", ob_swaps, 0);
        chk(1, "t6_step_count", 32'(ob_sc), 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
